pong_timer: RTL

Game-speed timer for the Pong datapath, sitting directly upstream of `control`. It consumes `control`'s `MAXTIME`/`SETTIME` timer controls and produces the single-cycle `TICK` that advances the ball state machine. The ball period starts at a maximum on a new serve. Each successful return shortens it, saturating at a minimum, so rallies speed up.

---
 rtl/pong_pkg.sv | 15 +
 rtl/pong_prescaler.sv | 19 +
 rtl/pong_timer.sv | 59 +++++
 3 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared timing defaults and the one-hot ball state type for the Pong datapath.
package pong_pkg;
  localparam int PRESCALE_DEF   = 50000;
  localparam int MAX_PERIOD_DEF = 16;
  localparam int MIN_PERIOD_DEF = 4;
  localparam int STEP_DEF       = 2;
  typedef enum logic [5:0] {
    INIT   = 6'b000001,
    MOVE_R = 6'b000010,
    END_R  = 6'b000100,
    MOVE_L = 6'b001000,
    END_L  = 6'b010000,
    DONE   = 6'b100000
  } state_t;
endpackage

// File: rtl/pong_prescaler.sv
// pong_prescaler: divide-by-PRESCALE time base; unit_o marks the last clock of each unit.
module pong_prescaler
  import pong_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic unit_o
);
  localparam int W = $clog2(PRESCALE);
  logic [W-1:0] pcnt_q, pcnt_d;
  assign unit_o = pcnt_q == W'(PRESCALE - 1);
  always_comb pcnt_d = (clr_i || unit_o) ? '0 : pcnt_q + W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pcnt_q <= '0;
    else pcnt_q <= pcnt_d;
endmodule

// File: rtl/pong_timer.sv
// pong_timer: game-speed timer producing TICK every PRESCALE*PERIOD clocks; MAXTIME/SETTIME restart it.
// Define PONG_SPEEDUP_EN to let SETTIME shorten PERIOD by STEP down to MIN_PERIOD.
module pong_timer
  import pong_pkg::*;
#(
  parameter int PRESCALE   = PRESCALE_DEF,
  parameter int MAX_PERIOD = MAX_PERIOD_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF,
  parameter int STEP       = STEP_DEF,
  localparam int PW        = $clog2(MAX_PERIOD + 1)
) (
  input  logic          CLK,
  input  logic          CLRN,
  input  logic          MAXTIME,
  input  logic          SETTIME,
  output logic          TICK,
  output logic [PW-1:0] PERIOD
);
  logic restart, unit, wrap, tick_q, tick_d;
  logic [PW-1:0] ucnt_q, ucnt_d, period_q, period_d;
  if (PRESCALE < 2 || MIN_PERIOD < 1 || STEP < 1 || MAX_PERIOD < MIN_PERIOD) begin : g_bad_params
    $error("pong_timer: illegal parameter combination");
  end
  assign restart = MAXTIME | SETTIME;
  pong_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk   (CLK),
    .rst_n (CLRN),
    .clr_i (restart),
    .unit_o(unit)
  );
  assign wrap = unit && ucnt_q == period_q - PW'(1);
  always_comb begin
    ucnt_d = (restart || wrap) ? '0 : unit ? ucnt_q + PW'(1) : ucnt_q;
    tick_d = !restart && wrap;
  end
`ifdef PONG_SPEEDUP_EN
  // Widened compare so MIN_PERIOD+STEP never wraps against a small period.
  localparam logic [PW:0] THR = (PW + 1)'(MIN_PERIOD + STEP);
  always_comb
    period_d = MAXTIME ? PW'(MAX_PERIOD)
             : !SETTIME ? period_q
             : ({1'b0, period_q} >= THR) ? period_q - PW'(STEP)
             : PW'(MIN_PERIOD);
`else
  assign period_d = PW'(MAX_PERIOD);
`endif
  always_ff @(posedge CLK or negedge CLRN)
    if (!CLRN) begin
      tick_q   <= 1'b0;
      ucnt_q   <= '0;
      period_q <= PW'(MAX_PERIOD);
    end else begin
      tick_q   <= tick_d;
      ucnt_q   <= ucnt_d;
      period_q <= period_d;
    end
  assign TICK   = tick_q;
  assign PERIOD = period_q;
endmodule
